// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
//   8N1 UART receiver, LSB first, 16x oversampling with 3-sample majority vote.
//   Delivers each correctly framed byte with a single-cycle strobe.
//
// Parameters
//   DIV        clk_i cycles per oversample tick (2..65535)
//
// Ports
//   clk_i      system clock, rising edge
//   rst_i      asynchronous active-high reset
//   rx_i       raw serial line, asynchronous, idle high
//   rx_byte    last correctly framed byte, held until the next good frame
//   received   one-cycle pulse: rx_byte has just been updated
//   frame_err  one-cycle pulse: stop bit sampled low, byte discarded
//   rx_busy    high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_rx_byte #(
    parameter int unsigned DIV = 54
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] rx_byte,
    output logic       received,
    output logic       frame_err,
    output logic       rx_busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_d;
    logic        rx_meta, rx_s;
    logic [15:0] div_cnt;
    logic        tick;
    logic [3:0]  s_cnt_q, s_cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  smp_q, smp_d;
    logic        armed_q, armed_d;
    logic [7:0]  rx_byte_d;
    logic        received_d, frame_err_d;
    logic        vote_mid, vote_stop;

    // Two-flop synchronizer; flops reset to the idle line level so that
    // reset itself never looks like a start bit.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    // Free-running oversample tick; never resynchronised to a frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 16'd1;
    end

    assign tick = (div_cnt == 16'(DIV - 1));

    // Bits are voted from the samples at s_cnt 7, 8, 9. The stop bit is
    // decided on the s_cnt=9 tick itself, so its third sample is the live rx_s.
    assign vote_mid  = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    assign vote_stop = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s)     | (smp_q[1] & rx_s);

    // NOTE: every signal driven here gets a default first, so no path through
    // the block can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        s_cnt_d     = tick ? s_cnt_q + 4'd1 : s_cnt_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        smp_d       = smp_q;
        armed_d     = armed_q;
        rx_byte_d   = rx_byte;
        received_d  = 1'b0;
        frame_err_d = 1'b0;

        if (tick) begin
            case (s_cnt_q)
                4'd7:    smp_d[0] = rx_s;
                4'd8:    smp_d[1] = rx_s;
                4'd9:    smp_d[2] = rx_s;
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                // Arming on a high sample keeps a stuck-low line or break from
                // retriggering frames.
                if (tick) begin
                    if (rx_s)         armed_d = 1'b1;
                    else if (armed_q) state_d = START;
                end
            end
            START: begin
                if (tick && s_cnt_q == 4'd15) begin
                    if (!vote_mid) begin
                        state_d = DATA;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = IDLE;      // false start, no pulse
                        armed_d = 1'b0;
                    end
                end
            end
            DATA: begin
                if (tick && s_cnt_q == 4'd15) begin
                    shreg_d = {vote_mid, shreg_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                // Decided early so the rest of the stop bit is left for
                // re-arming before a back-to-back start bit.
                if (tick && s_cnt_q == 4'd9) begin
                    if (vote_stop) begin
                        rx_byte_d  = shreg_q;
                        received_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                    armed_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) s_cnt_d = 4'd0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            s_cnt_q   <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            smp_q     <= '0;
            armed_q   <= 1'b0;
            rx_byte   <= '0;
            received  <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_cnt_q   <= s_cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            smp_q     <= smp_d;
            armed_q   <= armed_d;
            rx_byte   <= rx_byte_d;
            received  <= received_d;
            frame_err <= frame_err_d;
            rx_busy   <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_byte
//   Self-checking bench for uart_rx_byte with DIV=4 (one bit = 64 clocks).
//   A scoreboard queue holds the event expected for each frame driven; the
//   monitor pops and compares on every received / frame_err pulse.
// -----------------------------------------------------------------------------
module tb_uart_rx_byte;

    localparam int BIT = 64;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       rx_i;
    logic [7:0] rx_byte;
    logic       received;
    logic       frame_err;
    logic       rx_busy;

    uart_rx_byte #(.DIV(4)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rx_i      (rx_i),
        .rx_byte   (rx_byte),
        .received  (received),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
    } vec_t;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cycle = 0;
    int         rx_count = 0;
    int         err_count = 0;
    int         last_rx_cycle = 0;
    logic       prev_pulse = 1'b0;
    logic [7:0] exp_last = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(posedge clk_i) cycle <= cycle + 1;

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (received || frame_err) begin
            check("pulse_exclusive", {31'd0, received & frame_err}, 0);
            check("pulse_width", {31'd0, prev_pulse}, 0);
            check("event_expected", {31'd0, sb_q.size() != 0}, 1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("event_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                check(e.is_err ? "err_keeps_byte" : "rx_byte", {24'd0, rx_byte}, {24'd0, e.data});
            end
        end
        if (received) begin
            rx_count++;
            last_rx_cycle = cycle;
        end
        if (frame_err) err_count++;
        prev_pulse = received | frame_err;
    end

    task automatic drive(input logic v, input int n);
        rx_i = v;
        repeat (n) @(negedge clk_i);
    endtask

    // Full 8N1 frame; spike_bit >= 0 places a 4-clock low glitch in the
    // middle of that data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int spike_bit);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) begin
            if (i == spike_bit) begin
                drive(1'b1, 36);
                drive(1'b0, 4);
                drive(1'b1, 24);
            end else begin
                drive(d[i], BIT);
            end
        end
        drive(stop, BIT);
    endtask

    task automatic push_exp(input logic is_err, input logic [7:0] d);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        sb_q.push_back(e);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   r0, e0, c_prev;
        logic saw_busy;

        vecs[0] = '{8'h80, 1'b1, 5};
        vecs[1] = '{8'hA5, 1'b1, 3};
        vecs[2] = '{8'h3C, 1'b1, 0};
        vecs[3] = '{8'h00, 1'b1, 2};
        vecs[4] = '{8'hC3, 1'b1, 0};
        vecs[5] = '{8'h7E, 1'b1, 1};

        rst_i = 1'b1;
        rx_i  = 1'b1;
        repeat (3) @(negedge clk_i);
        check("reset_rx_byte",   {24'd0, rx_byte}, 0);
        check("reset_received",  {31'd0, received}, 0);
        check("reset_frame_err", {31'd0, frame_err}, 0);
        check("reset_rx_busy",   {31'd0, rx_busy}, 0);
        rst_i = 1'b0;

        // Good frames, with and without idle gaps.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].gap * BIT);
            r0     = rx_count;
            c_prev = last_rx_cycle;
            push_exp(1'b0, vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop, -1);
            check("vec_rx_count", rx_count - r0, 1);
            check("vec_rx_byte", {24'd0, rx_byte}, {24'd0, vecs[i].data});
            check("vec_busy_after", {31'd0, rx_busy}, 0);
            if (vecs[i].gap == 0) check("b2b_spacing", last_rx_cycle - c_prev, 640);
            exp_last = vecs[i].data;
        end

        // False start: 20-clock low pulse.
        drive(1'b1, 2 * BIT);
        r0 = rx_count;
        e0 = err_count;
        saw_busy = 1'b0;
        rx_i = 1'b0;
        repeat (20) begin
            @(negedge clk_i);
            if (rx_busy) saw_busy = 1'b1;
        end
        rx_i = 1'b1;
        repeat (3 * BIT) begin
            @(negedge clk_i);
            if (rx_busy) saw_busy = 1'b1;
        end
        check("fs_busy_seen", {31'd0, saw_busy}, 1);
        check("fs_busy_end", {31'd0, rx_busy}, 0);
        check("fs_no_rx", rx_count - r0, 0);
        check("fs_no_err", err_count - e0, 0);

        // Bad stop bit followed by a long break.
        r0 = rx_count;
        e0 = err_count;
        push_exp(1'b1, exp_last);
        send_frame(8'h55, 1'b0, -1);
        check("brk_err_count", err_count - e0, 1);
        check("brk_rx_count", rx_count - r0, 0);
        drive(1'b0, 10 * BIT);
        check("brk_busy_mid", {31'd0, rx_busy}, 0);
        check("brk_byte_mid", {24'd0, rx_byte}, {24'd0, exp_last});
        drive(1'b0, 10 * BIT);
        check("brk_err_after", err_count - e0, 1);
        check("brk_rx_after", rx_count - r0, 0);
        drive(1'b1, 2 * BIT);
        push_exp(1'b0, 8'h01);
        send_frame(8'h01, 1'b1, -1);
        check("brk_recover", {24'd0, rx_byte}, 8'h01);
        exp_last = 8'h01;

        // Reset in the middle of data bit 4 of 0xF0.
        drive(1'b1, BIT);
        r0 = rx_count;
        e0 = err_count;
        drive(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(1'b0, BIT);
        drive(1'b1, BIT / 2);
        check("rst_busy_before", {31'd0, rx_busy}, 1);
        rst_i = 1'b1;
        #1;
        check("rst_rx_byte",   {24'd0, rx_byte}, 0);
        check("rst_received",  {31'd0, received}, 0);
        check("rst_frame_err", {31'd0, frame_err}, 0);
        check("rst_rx_busy",   {31'd0, rx_busy}, 0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        exp_last = 8'h00;
        drive(1'b1, 2 * BIT);
        check("rst_no_rx", rx_count - r0, 0);
        check("rst_no_err", err_count - e0, 0);
        push_exp(1'b0, 8'h0F);
        send_frame(8'h0F, 1'b1, -1);
        check("rst_recover", {24'd0, rx_byte}, 8'h0F);

        // One-sample glitch in data bit 3 must be voted out.
        drive(1'b1, BIT);
        r0 = rx_count;
        push_exp(1'b0, 8'hFF);
        send_frame(8'hFF, 1'b1, 3);
        check("spike_rx_count", rx_count - r0, 1);
        check("spike_rx_byte", {24'd0, rx_byte}, 8'hFF);

        drive(1'b1, 2 * BIT);
        check("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Serial receive front end of the IO hub. It turns the PC-to-Atlys UART line into whole bytes and marks each one with a single-cycle strobe. It sits directly upstream of the header/payload assembler, which consumes `rx_byte`/`received` to detect the 0x80 header and build 16-bit words. The line format is 8N1, LSB first, with 16x oversampling and 3-sample majority voting.

## Interface
- `DIV`, 54: `clk_i` cycles per oversample tick. 100 MHz / (115200 × 16) ≈ 54. Legal range 2..65535.
- `clk_i` in 1: system clock; all logic is on the rising edge.
- `rst_i` in 1: asynchronous, active-high reset. Single clock; reset is asynchronous and active-high.
- `rx_i` in 1: raw serial line, asynchronous to `clk_i`, idle high.
- `rx_byte` out 8: last correctly framed byte. Held until the next good frame.
- `received` out 1: one-`clk_i` pulse; a new `rx_byte` is valid.
- `frame_err` out 1: one-`clk_i` pulse; stop bit sampled low, byte discarded.
- `rx_busy` out 1: high while a frame is in progress.

## Operation
- Synchronizer: `rx_i` passes through 2 flip-flops (`rx_s`). All decisions use `rx_s` only.
- Tick generator: 16-bit counter runs 0..DIV-1 and wraps. `tick`=1 for one cycle when counter==DIV-1. It runs freely and is never restarted by a frame.
- Sample counter `s_cnt`, 4 bits. Advances only on `tick`. Cleared on every state change.
- Majority voter: captures `rx_s` at ticks with `s_cnt`=7, 8, 9. Bit value = at least 2 of 3 ones.
- `armed` flag: cleared at reset and at any frame end. Set on a tick with `rx_s`=1 while in IDLE. This blocks triggering on a stuck-low line or break.
- IDLE: on a tick with `armed`=1 and `rx_s`=0, go to START (`s_cnt`=0).
- START: at the tick with `s_cnt`=15, evaluate the vote:
  - 0: go to DATA, bit index 0.
  - 1: false start. Go to IDLE with no output pulse.
- DATA: at the tick with `s_cnt`=15, shift the vote into bit 7 of the shift register, shifting right (LSB first).
  - Bit index 7 done: go to STOP.
  - Otherwise: increment the bit index.
- STOP: evaluated early, at the tick with `s_cnt`=9, to allow resync for back-to-back frames:
  - Vote 1: `rx_byte` ← shift register, `received` pulse.
  - Vote 0: `frame_err` pulse; `rx_byte` unchanged.
  - Either way: go to IDLE, `armed`=0.
- `rx_busy` = state ≠ IDLE. It is registered with the state.
- `received` and `frame_err` are never high in the same cycle. Each pulses at most once per frame.

## Timing
- Reset values: `rx_byte`=0x00, `received`=0, `frame_err`=0, `rx_busy`=0, state IDLE, `armed`=0, all counters 0, synchronizer flip-flops 1.
- Reset takes effect immediately, including mid-frame. The partial byte is lost. Reception restarts only after reset deasserts and `rx_s` is seen high at a tick.
- Bit period = 16 × DIV clocks.
- Start edge detection is delayed by 2 sync cycles plus up to 1 tick period (DIV cycles).
- `received`/`frame_err` rise on the clock edge following the STOP evaluation tick. This is about 9.6 bit periods after the start edge. They stay high exactly 1 cycle.
- `rx_byte` changes on the same edge that `received` rises and is stable until the next `received`.
- There is no backpressure. A consumer must sample `rx_byte` within 1 byte time (10 bit periods) of `received`.
- Back-to-back frames, with the next start bit right after the stop bit, are received without loss. Tolerance is ±3% baud mismatch.
- A low pulse on the line shorter than 8 ticks at start is rejected as a false start.

## Test plan
Bench uses `DIV`=4, so 1 bit = 64 clocks. Line is driven from a bit-period model.
- Idle high 5 bits, then send 0x80. Expect exactly one `received`, `rx_byte`=0x80, `frame_err`=0, and `rx_busy` low after the pulse.
- Send 0xA5 then 0x3C back-to-back with no idle gap. Expect two `received` pulses about 640 clocks apart, `rx_byte` 0xA5 then 0x3C.
- Drive the line low for 20 clocks (5 ticks), then high. Expect `rx_busy` to rise then fall, with no `received` and no `frame_err`.
- Send 0x55 with the stop bit driven low, then hold low for 20 bit periods, then high, then send 0x01. Expect:
  - exactly one `frame_err` pulse and no `received`;
  - `rx_byte` keeps its prior value during the break, with no further events while low;
  - after the line returns high, 0x01 is received correctly.
- Assert `rst_i` for 3 clocks mid-data-bit 4 of 0xF0. Expect all outputs at reset values immediately and no pulse for the aborted frame. A subsequent 0x0F is received correctly.
- Send 0xFF with a 4-clock low spike covering only the `s_cnt`=8 sample of data bit 3. Expect `rx_byte`=0xFF (majority vote) and `received` pulse.
